// File: rtl/uart_tx_shifter.sv
// UART transmit shifter: captures a byte on the upstream enable level and shifts it out LSB-first,
// paced by rising edges of the 9600 Hz baud square wave. It pulses charSent when the frame is done.
//
// state    | meaning
// IDLE     | line high, waiting for enable to capture data
// START    | start bit (tx low) until the first tick after capture
// DATA     | data bits, LSB first, one per tick
// PARITY   | optional parity bit
// STOP     | stop bit(s); the last stop tick raises charSent
// WAIT_LOW | frame done, hold until enable drops so a held enable cannot retransmit
module uart_tx_shifter #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clk9600,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 charSent,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS) + 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] PARITY   = 3'd3;
    localparam logic [2:0] STOP     = 3'd4;
    localparam logic [2:0] WAIT_LOW = 3'd5;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

    logic [2:0]           state;
    logic                 clk9600Q;
    logic                 tick;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 parityBit;
    logic [CNT_W-1:0]     bitCnt;
    logic [1:0]           stopCnt;

    assign tick = clk9600 & ~clk9600Q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            clk9600Q  <= 1'b0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            bitCnt    <= '0;
            stopCnt   <= '0;
            tx        <= 1'b1;
            charSent  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            clk9600Q <= clk9600;
            charSent <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    // A tick landing on this capture cycle is deliberately ignored.
                    if (enable) begin
                        shiftReg  <= data;
                        parityBit <= (^data) ^ (PARITY_ODD != 0);
                        bitCnt    <= '0;
                        stopCnt   <= '0;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx    <= shiftReg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shiftReg <= shiftReg >> 1;
                        bitCnt   <= bitCnt + 1'b1;
                        if (bitCnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parityBit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            tx <= shiftReg[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (tick) begin
                        if (stopCnt == LAST_STOP) begin
                            charSent <= 1'b1;
                            busy     <= 1'b0;
                            state    <= WAIT_LOW;
                        end else begin
                            stopCnt <= stopCnt + 1'b1;
                        end
                    end
                end
                WAIT_LOW: begin
                    tx <= 1'b1;
                    if (!enable) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Bench for uart_tx_shifter: three instances (default, odd parity, two stop bits) driven by a
// shared 16-clk baud square wave; frames come from a vector table, corner cases are hand sequences.
module tb_uart_tx_shifter;

    typedef struct {
        int          sel;
        logic [7:0]  d;
        int          nBits;
        logic [11:0] exp;
        int          holdAfter;
        bit          midChange;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] baudCnt = 4'd0;
    logic       baudHold = 1'b0;
    logic       clk9600;
    logic [2:0] en = 3'b000;
    logic [7:0] dataIn = 8'h00;
    logic       txA, txB, txC, busyA, busyB, busyC, csA, csB, csC;
    logic [2:0] txV, busyV, csV;

    int passCnt = 0;
    int totalCnt = 0;
    int busyCnt = 0;
    int csCnt = 0;
    int curSel = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!baudHold) baudCnt <= baudCnt + 4'd1;
    end
    assign clk9600 = (baudCnt < 4'd8);

    assign txV   = {txC, txB, txA};
    assign busyV = {busyC, busyB, busyA};
    assign csV   = {csC, csB, csA};

    uart_tx_shifter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dutA (
        .clk(clk), .reset(reset), .enable(en[0]), .clk9600(clk9600), .data(dataIn),
        .tx(txA), .charSent(csA), .busy(busyA));

    uart_tx_shifter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dutB (
        .clk(clk), .reset(reset), .enable(en[1]), .clk9600(clk9600), .data(dataIn),
        .tx(txB), .charSent(csB), .busy(busyB));

    uart_tx_shifter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dutC (
        .clk(clk), .reset(reset), .enable(en[2]), .clk9600(clk9600), .data(dataIn),
        .tx(txC), .charSent(csC), .busy(busyC));

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        if (busyV[curSel]) busyCnt++;
        if (csV[curSel]) csCnt++;
    endtask

    task automatic waitRise(input string name);
        bit prev;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            prev = clk9600;
            step();
            if (!prev && clk9600) seen = 1'b1;
        end
        if (!seen) check({name, " baud timeout"}, 0, 1);
    endtask

    task automatic runFrame(input vec_t v, input int idx);
        int txLow;
        curSel = v.sel;
        dataIn = v.d;
        waitRise($sformatf("v%0d align", idx));
        step();
        en[v.sel] = 1'b1;
        busyCnt = 0;
        csCnt = 0;
        repeat (4) step();
        check($sformatf("v%0d bit0", idx), int'(txV[v.sel]), int'(v.exp[0]));
        for (int i = 1; i < v.nBits; i++) begin
            waitRise($sformatf("v%0d bit%0d", idx, i));
            repeat (8) step();
            check($sformatf("v%0d bit%0d", idx, i), int'(txV[v.sel]), int'(v.exp[i]));
            if (v.midChange && i == 3) begin
                dataIn = 8'hF0;
                en[v.sel] = 1'b0;
            end
        end
        waitRise($sformatf("v%0d end", idx));
        step();
        check($sformatf("v%0d charSent", idx), int'(csV[v.sel]), 1);
        check($sformatf("v%0d busy end", idx), int'(busyV[v.sel]), 0);
        step();
        check($sformatf("v%0d charSent drop", idx), int'(csV[v.sel]), 0);
        check($sformatf("v%0d pulse count", idx), csCnt, 1);
        check($sformatf("v%0d busy length", idx), busyCnt, v.nBits * 16 - 1);
        if (v.holdAfter > 0) begin
            busyCnt = 0;
            txLow = 0;
            repeat (v.holdAfter) begin
                step();
                if (!txV[v.sel]) txLow++;
            end
            check($sformatf("v%0d held busy", idx), busyCnt, 0);
            check($sformatf("v%0d held tx low", idx), txLow, 0);
            check($sformatf("v%0d held pulses", idx), csCnt, 1);
        end
        en[v.sel] = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        int txLow;
        vecs[0] = '{0, 8'h55, 10, 12'b0010_1010_1010, 48, 1'b0};
        vecs[1] = '{0, 8'hA3, 10, 12'b0011_0100_0110, 0, 1'b0};
        vecs[2] = '{1, 8'h03, 11, 12'b0110_0000_0110, 0, 1'b0};
        vecs[3] = '{1, 8'h07, 11, 12'b0100_0000_1110, 0, 1'b0};
        vecs[4] = '{2, 8'hFF, 11, 12'b0111_1111_1110, 0, 1'b0};
        vecs[5] = '{0, 8'h0F, 10, 12'b0010_0001_1110, 0, 1'b1};

        repeat (3) step();
        check("reset tx", int'(txV), 7);
        check("reset busy", int'(busyV), 0);
        check("reset charSent", int'(csV), 0);
        reset = 1'b1;
        repeat (2) step();

        for (int n = 0; n < 6; n++) runFrame(vecs[n], n);

        // Reset arriving while data bit 3 (a zero for 0x55) is on the line.
        curSel = 0;
        dataIn = 8'h55;
        waitRise("rst align");
        step();
        en[0] = 1'b1;
        repeat (4) waitRise("rst bit");
        repeat (4) step();
        check("pre-reset tx", int'(txA), 0);
        check("pre-reset busy", int'(busyA), 1);
        reset = 1'b0;
        #1;
        check("async reset tx", int'(txA), 1);
        check("async reset busy", int'(busyA), 0);
        check("async reset charSent", int'(csA), 0);
        en[0] = 1'b0;
        step();
        reset = 1'b1;
        busyCnt = 0;
        csCnt = 0;
        txLow = 0;
        repeat (40) begin
            step();
            if (!txA) txLow++;
        end
        check("post-reset tx low", txLow, 0);
        check("post-reset busy", busyCnt, 0);
        check("post-reset charSent", csCnt, 0);

        // Frozen baud wave: capture happens, then the frame sits in the start bit.
        baudHold = 1'b1;
        step();
        en[0] = 1'b1;
        busyCnt = 0;
        csCnt = 0;
        txLow = 0;
        repeat (48) begin
            step();
            if (!txA) txLow++;
        end
        check("stall busy", busyCnt, 48);
        check("stall tx low", txLow, 48);
        check("stall charSent", csCnt, 0);
        reset = 1'b0;
        step();
        en[0] = 1'b0;
        baudHold = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        check("stall reset tx", int'(txA), 1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
